// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: synchronises rx, samples each bit at mid-bit and hands
// bytes out over a valid/ready interface, flagging framing errors and overruns.
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    // Handshake: a byte is transferred on every rising edge where valid && ready;
    // data_out is held stable while valid=1 and ready=0.

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    logic                   rs_prev;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [2:0]             idx;
    logic [2:0]             idx_nxt;
    logic [7:0]             shift;
    logic                   sample_bit;
    logic                   byte_done;
    logic                   stop_bad;

    assign rs   = sync_q[SYNC_STAGES-1];
    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + CNT_W'(1);
        idx_nxt    = idx;
        sample_bit = 1'b0;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (!rs && rs_prev) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                // Mid start bit: a line back high here was only a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt    = '0;
                    sample_bit = 1'b1;
                    idx_nxt    = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rs) begin
                        byte_done = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must rise before another start can be seen.
                cnt_nxt = '0;
                if (rs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= '1;
            rs_prev <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
            rs_prev <= rs;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            if (sample_bit) begin
                shift[idx] <= rs;
            end
        end
    end

    // Output register: a completing byte may replace one being consumed on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done && valid && !ready;
            if (byte_done && (!valid || ready)) begin
                data_out <= shift;
                valid    <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: frame-level event model, per-cycle compare,
// byte scoreboard on handshakes, plus literal checks per scenario.
module tb_uart_rx_deser;
    localparam int CPB  = 16;
    localparam int SYNC = 2;
    // Stop-sample edge relative to the cycle the start bit is driven.
    localparam int LAT  = SYNC + 1 + CPB / 2 + 9 * CPB;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_deser #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         at;
        logic [7:0] data;
        bit         ferr;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] exp_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Frame-level model: each frame resolves at its stop-sample edge.
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;
    ev_t        m_ev;
    bit         m_done;

    initial forever begin
        @(posedge clk);
        cyc    = cyc + 1;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_done = 1'b0;
        if (!rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            ev_q.delete();
        end else begin
            if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
                m_ev   = ev_q.pop_front();
                m_done = 1'b1;
            end
            if (m_done && m_ev.ferr) m_ferr = 1'b1;
            if (m_done && !m_ev.ferr) begin
                if (!m_valid || ready) begin
                    m_data  = m_ev.data;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle compare, pulse counters and handshake scoreboard.
    bit   run_cmp    = 1'b0;
    logic prev_valid = 1'b0;
    int   n_ferr     = 0;
    int   n_ovr      = 0;
    int   n_vrise    = 0;

    initial forever begin
        @(negedge clk);
        if (run_cmp) begin
            chk("valid", 32'(valid), 32'(m_valid));
            chk("data_out", 32'(data_out), 32'(m_data));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            if (frame_err === 1'b1) n_ferr++;
            if (overrun === 1'b1) n_ovr++;
            if (valid === 1'b1 && prev_valid !== 1'b1) n_vrise++;
            if (valid === 1'b1 && ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL consume: got byte %0h expected no byte at cycle %0d", data_out, cyc);
                end else begin
                    chk("consume", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
            prev_valid = valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        int n;
        n = 0;
        while (cyc < t && n < 5000) begin
            tick();
            n++;
        end
        if (cyc < t) chk("wait_timeout", 32'(cyc), 32'(t));
    endtask

    // Drives one frame; rst_bit >= 0 pulses reset mid-way through that frame bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit,
                              input bit expect_byte);
        logic [9:0] bits;
        ev_t        ev;
        int         k;
        bits = {stop, b, 1'b0};
        k    = cyc;
        if (rst_bit < 0) begin
            ev.at   = k + LAT;
            ev.data = b;
            ev.ferr = !stop;
            ev_q.push_back(ev);
            if (stop && expect_byte) exp_q.push_back(b);
        end
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int j = 0; j < CPB; j++) begin
                if (i == rst_bit && j == CPB / 2) rst = 1'b0;
                tick();
                rst = 1'b1;
            end
        end
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        summary();
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int s_ferr;
        int s_ovr;
        int s_vr;

        repeat (3) tick();
        rst     = 1'b1;
        run_cmp = 1'b1;
        @(negedge clk);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        repeat (5) tick();

        // 1: single byte, ready high; valid first visible after edge k+155.
        ready  = 1'b1;
        s_ferr = n_ferr; s_ovr = n_ovr; s_vr = n_vrise;
        k      = cyc;
        fork
            send_frame(8'hA5, 1'b1, -1, 1'b1);
            begin
                wait_until(k + 154);
                @(negedge clk);
                chk("t1_valid_early", 32'(valid), 32'h0);
                tick();
                @(negedge clk);
                chk("t1_valid", 32'(valid), 32'h1);
                chk("t1_data", 32'(data_out), 32'hA5);
            end
        join
        repeat (4) tick();
        chk("t1_vrise", 32'(n_vrise - s_vr), 32'd1);
        chk("t1_ferr", 32'(n_ferr - s_ferr), 32'd0);
        chk("t1_ovr", 32'(n_ovr - s_ovr), 32'd0);

        // 2: back-to-back with ready low; second byte overruns.
        ready = 1'b0;
        repeat (10) tick();
        s_ovr = n_ovr;
        send_frame(8'h3C, 1'b1, -1, 1'b1);
        send_frame(8'hC3, 1'b1, -1, 1'b0);
        @(negedge clk);
        chk("t2_valid", 32'(valid), 32'h1);
        chk("t2_data", 32'(data_out), 32'h3C);
        chk("t2_ovr", 32'(n_ovr - s_ovr), 32'd1);
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        @(negedge clk);
        chk("t2_valid_clr", 32'(valid), 32'h0);

        // 3: 5-cycle glitch is rejected at mid start bit.
        repeat (10) tick();
        s_ferr = n_ferr; s_ovr = n_ovr; s_vr = n_vrise;
        k      = cyc;
        rx     = 1'b0;
        repeat (5) tick();
        rx = 1'b1;
        @(negedge clk);
        chk("t3_busy_hi", 32'(busy), 32'h1);
        wait_until(k + 20);
        @(negedge clk);
        chk("t3_busy_lo", 32'(busy), 32'h0);
        chk("t3_vrise", 32'(n_vrise - s_vr), 32'd0);
        chk("t3_ferr", 32'(n_ferr - s_ferr), 32'd0);
        chk("t3_ovr", 32'(n_ovr - s_ovr), 32'd0);

        // 4: bad stop bit, line held low, then a good byte.
        tick();
        s_ferr = n_ferr; s_vr = n_vrise;
        send_frame(8'h55, 1'b0, -1, 1'b0);
        repeat (40) tick();
        @(negedge clk);
        chk("t4_busy_break", 32'(busy), 32'h1);
        tick();
        rx = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        chk("t4_busy_idle", 32'(busy), 32'h0);
        chk("t4_ferr", 32'(n_ferr - s_ferr), 32'd1);
        chk("t4_no_byte", 32'(n_vrise - s_vr), 32'd0);
        tick();
        send_frame(8'h0F, 1'b1, -1, 1'b1);
        @(negedge clk);
        chk("t4_valid", 32'(valid), 32'h1);
        chk("t4_data", 32'(data_out), 32'h0F);
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // 5: reset during data bit 4 of 0xFF (frame bit 5), then 0x81.
        repeat (5) tick();
        s_vr = n_vrise;
        send_frame(8'hFF, 1'b1, 5, 1'b0);
        @(negedge clk);
        chk("t5_data_rst", 32'(data_out), 32'h0);
        chk("t5_valid_rst", 32'(valid), 32'h0);
        chk("t5_busy_rst", 32'(busy), 32'h0);
        chk("t5_no_byte", 32'(n_vrise - s_vr), 32'd0);
        tick();
        ready = 1'b1;
        send_frame(8'h81, 1'b1, -1, 1'b1);
        @(negedge clk);
        chk("t5_data", 32'(data_out), 32'h81);
        chk("t5_vrise", 32'(n_vrise - s_vr), 32'd1);

        // 6: ready rises exactly on the stop-sample edge of 0x34 while 0x12 is held.
        tick();
        ready = 1'b0;
        repeat (5) tick();
        send_frame(8'h12, 1'b1, -1, 1'b1);
        @(negedge clk);
        chk("t6_hold_data", 32'(data_out), 32'h12);
        tick();
        s_ovr = n_ovr;
        k     = cyc;
        fork
            send_frame(8'h34, 1'b1, -1, 1'b1);
            begin
                wait_until(k + 154);
                ready = 1'b1;
                tick();
                ready = 1'b0;
                @(negedge clk);
                chk("t6_valid", 32'(valid), 32'h1);
                chk("t6_data", 32'(data_out), 32'h34);
            end
        join
        chk("t6_ovr", 32'(n_ovr - s_ovr), 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        repeat (5) tick();

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("ev_q_empty", 32'(ev_q.size()), 32'd0);
        summary();
        $finish;
    end

endmodule
